// File: rtl/m65c02_lst_xfer.sv
// m65c02_lst_xfer: registered load/store/transfer operand selector for the
// M65C02A ALU path. Latches OAX/OAY/OSY prefixes, applies one to the next
// accepted LST operation, and holds the result on a valid/ack output stage.
`timescale 1ns/1ps

module m65c02_lst_xfer #(
    parameter int W      = 8,
    parameter bit OSY_EN = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_pfx_vld,
    input  logic [1:0]   i_pfx,
    input  logic         i_en,
    input  logic [2:0]   i_osel,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic [W-1:0] i_tmp,
    input  logic [W-1:0] i_s,
    input  logic [W-1:0] i_m,
    input  logic [7:0]   i_p,
    input  logic         i_ack,
    output logic [W:0]   o_out,
    output logic         o_val,
    output logic         o_busy,
    output logic [1:0]   o_pfx_act,
    output logic         o_pfx_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PFX  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] PFX_NONE = 2'd0;
    localparam logic [1:0] PFX_OAX  = 2'd1;
    localparam logic [1:0] PFX_OAY  = 2'd2;
    localparam logic [1:0] PFX_OSY  = 2'd3;

    localparam logic [2:0] SEL_X   = 3'd1;
    localparam logic [2:0] SEL_Y   = 3'd2;
    localparam logic [2:0] SEL_A   = 3'd3;
    localparam logic [2:0] SEL_TMP = 3'd4;
    localparam logic [2:0] SEL_S   = 3'd5;
    localparam logic [2:0] SEL_P   = 3'd6;
    localparam logic [2:0] SEL_M   = 3'd7;

    state_t       r_state;
    logic [W:0]   r_out;
    logic [1:0]   r_pfx_act;
    logic         r_pfx_err;

    logic         w_accept;
    logic [2:0]   w_sel;
    logic [W-1:0] w_operand;
    logic [1:0]   w_pfx_nxt;
    logic         w_pfx_load;
    logic         w_err_nxt;

    // Val is simply "in HOLD"; Busy blocks new ops until the consumer acks.
    assign o_val     = (r_state == HOLD);
    assign o_busy    = o_val & ~i_ack;
    assign w_accept  = i_en & ~o_busy;
    assign o_out     = r_out;
    assign o_pfx_act = r_pfx_act;
    assign o_pfx_err = r_pfx_err;

    // Rewrite the requested source according to the prefix latched before this edge.
    always_comb begin
        w_sel = i_osel;
        case (r_pfx_act)
            PFX_OAX: begin
                if (i_osel == SEL_X)      w_sel = SEL_A;
                else if (i_osel == SEL_A) w_sel = SEL_X;
            end
            PFX_OAY: begin
                if (i_osel == SEL_Y)      w_sel = SEL_A;
                else if (i_osel == SEL_A) w_sel = SEL_Y;
            end
            PFX_OSY: begin
                if (OSY_EN) begin
                    if (i_osel == SEL_Y)      w_sel = SEL_S;
                    else if (i_osel == SEL_S) w_sel = SEL_Y;
                end
            end
            default: w_sel = i_osel;
        endcase
    end

    // Operand multiplexer; P is zero-extended, unlisted selects give zero.
    always_comb begin
        w_operand = '0;
        case (w_sel)
            SEL_X:   w_operand = i_x;
            SEL_Y:   w_operand = i_y;
            SEL_A:   w_operand = i_a;
            SEL_TMP: w_operand = i_tmp;
            SEL_S:   w_operand = i_s;
            SEL_P:   w_operand = W'(i_p);
            SEL_M:   w_operand = i_m;
            default: w_operand = '0;
        endcase
    end

    // Next prefix: a new prefix wins over consumption; a differing replacement flags an error.
    always_comb begin
        w_pfx_nxt  = r_pfx_act;
        w_pfx_load = 1'b0;
        w_err_nxt  = 1'b0;
        if (i_pfx_vld) begin
            if (i_pfx == PFX_NONE) begin
                w_pfx_nxt = PFX_NONE;
            end else if ((i_pfx == PFX_OSY) && !OSY_EN) begin
                w_err_nxt = 1'b1;
            end else begin
                w_err_nxt  = (r_pfx_act != PFX_NONE) && (r_pfx_act != i_pfx);
                w_pfx_nxt  = i_pfx;
                w_pfx_load = 1'b1;
            end
        end
        if (w_accept && !w_pfx_load) begin
            w_pfx_nxt = PFX_NONE;
        end
    end

    // State machine with registered output word, prefix and error pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_out     <= '0;
            r_pfx_act <= PFX_NONE;
            r_pfx_err <= 1'b0;
        end else begin
            r_pfx_act <= w_pfx_nxt;
            r_pfx_err <= w_err_nxt;
            if (w_accept) begin
                r_out   <= {1'b0, w_operand};
                r_state <= HOLD;
            end else if ((r_state == HOLD) && !i_ack) begin
                r_state <= HOLD;
            end else if (w_pfx_nxt != PFX_NONE) begin
                r_state <= PFX;
            end else begin
                r_state <= IDLE;
            end
        end
    end

endmodule
